cond_unit: RTL and testbench

- Condition/flags stage directly downstream of the ALU in the ARM datapath.
- Holds the architectural NZCV flags register and captures ALU flags under control of flag_w.
- Evaluates the 4-bit instruction condition field against the stored flags.
- Gates the PC-write, register-write and memory-write strobes before they reach the register file, data memory and PC mux.

---
 rtl/arm_pkg.sv | 30 +++
 rtl/cond_check.sv | 48 ++++
 rtl/cond_unit.sv | 66 ++++++
 tb/tb_cond_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition encodings and NZCV flag positions.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ   = 4'b0000,
        COND_NE   = 4'b0001,
        COND_CS   = 4'b0010,
        COND_CC   = 4'b0011,
        COND_MI   = 4'b0100,
        COND_PL   = 4'b0101,
        COND_VS   = 4'b0110,
        COND_VC   = 4'b0111,
        COND_HI   = 4'b1000,
        COND_LS   = 4'b1001,
        COND_GE   = 4'b1010,
        COND_LT   = 4'b1011,
        COND_GT   = 4'b1100,
        COND_LE   = 4'b1101,
        COND_AL   = 4'b1110,
        COND_RSVD = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against the stored NZCV flags.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic       valid_in,
    output logic       cond_ex,
    output logic       illegal_cond
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ:   cond_ex = z;
            COND_NE:   cond_ex = ~z;
            COND_CS:   cond_ex = c;
            COND_CC:   cond_ex = ~c;
            COND_MI:   cond_ex = n;
            COND_PL:   cond_ex = ~n;
            COND_VS:   cond_ex = v;
            COND_VC:   cond_ex = ~v;
            COND_HI:   cond_ex = c & ~z;
            COND_LS:   cond_ex = ~c | z;
            COND_GE:   cond_ex = ~(n ^ v);
            COND_LT:   cond_ex = n ^ v;
            COND_GT:   cond_ex = ~z & ~(n ^ v);
            COND_LE:   cond_ex = z | (n ^ v);
            COND_AL:   cond_ex = 1'b1;
            COND_RSVD: cond_ex = 1'b0;
            default:   cond_ex = 1'b0;
        endcase
    end

    assign illegal_cond = valid_in & (cond == COND_NV);

endmodule

// File: rtl/cond_unit.sv
// Condition/flags stage after the ALU: holds NZCV, evaluates the condition
// field and gates the PC, register-file and memory write strobes.
module cond_unit
    import arm_pkg::*;
#(
    parameter int COND_W = 4,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [1:0]        flag_w,
    input  logic              pcs,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              no_write,
    output logic              pc_src,
    output logic              reg_write,
    output logic              mem_write,
    output logic              cond_ex,
    output logic              cond_ex_q,
    output logic              illegal_cond,
    output logic [FLAG_W-1:0] flags
);

    logic accept;

    assign accept = valid_in & ~stall & ~flush;

    cond_check u_cond_check (
        .cond         (cond),
        .flags        (flags),
        .valid_in     (valid_in),
        .cond_ex      (cond_ex),
        .illegal_cond (illegal_cond)
    );

    // Strobes are zero-latency: they reach the register file, memory and PC mux this cycle.
    assign pc_src    = pcs & cond_ex & accept;
    assign reg_write = reg_w & ~no_write & cond_ex & accept;
    assign mem_write = mem_w & cond_ex & accept;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags     <= '0;
            cond_ex_q <= 1'b0;
        end else if (accept) begin
            cond_ex_q <= cond_ex;
            if (cond_ex) begin
                // N,Z and C,V halves update independently; an unselected half holds.
                if (flag_w[1]) begin
                    flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
                end
                if (flag_w[0]) begin
                    flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
                end
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized vectors
// checked against a behavioural NZCV model.
module tb_cond_unit;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic       stall;
    logic       flush;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       cond_ex;
    logic       cond_ex_q;
    logic       illegal_cond;
    logic [3:0] flags;

    int n_vec;
    int n_bad;

    // Reference state
    logic [3:0] m_flags;
    logic       m_cq;

    cond_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .stall        (stall),
        .flush        (flush),
        .cond         (cond),
        .alu_flags    (alu_flags),
        .flag_w       (flag_w),
        .pcs          (pcs),
        .reg_w        (reg_w),
        .mem_w        (mem_w),
        .no_write     (no_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .mem_write    (mem_write),
        .cond_ex      (cond_ex),
        .cond_ex_q    (cond_ex_q),
        .illegal_cond (illegal_cond),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; bit 0 selects the inverted sense.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    // Applies one instruction starting just after a rising edge, checks the
    // combinational outputs mid-cycle, then the registered state after the edge.
    task automatic apply(input logic v, input logic st, input logic fl, input logic [3:0] c,
                         input logic [3:0] af, input logic [1:0] fw, input logic p,
                         input logic rw, input logic mw, input logic nw);
        logic acc, ce;
        valid_in = v; stall = st; flush = fl; cond = c; alu_flags = af;
        flag_w = fw; pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
        #3;
        acc = v && !st && !fl;
        ce  = ref_cond(c, m_flags);
        check("cond_ex",      cond_ex,      ce);
        check("illegal_cond", illegal_cond, v && (c == 4'hF));
        check("pc_src",       pc_src,       p && ce && acc);
        check("reg_write",    reg_write,    rw && !nw && ce && acc);
        check("mem_write",    mem_write,    mw && ce && acc);
        @(posedge clk);
        if (acc) begin
            m_cq = ce;
            if (ce && fw[1]) m_flags[3:2] = af[3:2];
            if (ce && fw[0]) m_flags[1:0] = af[1:0];
        end
        #1;
        check("flags",     flags,     m_flags);
        check("cond_ex_q", cond_ex_q, m_cq);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        m_flags = 4'h0; m_cq = 1'b0;
        valid_in = 0; stall = 0; flush = 0; cond = 4'hE; alu_flags = 0;
        flag_w = 0; pcs = 0; reg_w = 0; mem_w = 0; no_write = 0;
        rst_n = 1'b0;
        #2;
        check("rst_flags",     flags,     4'h0);
        check("rst_cond_ex_q", cond_ex_q, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: AL register write straight out of reset
        apply(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
        check("p1_flags", flags, 4'h0);

        // 2: CMP equal sets Z, then EQ passes and NE fails
        apply(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
        check("p2_flags", flags, 4'b0100);
        apply(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
        apply(1, 0, 0, 4'h1, 4'h0, 2'b00, 0, 0, 1, 0);

        // 3: partial updates
        apply(1, 0, 0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        apply(1, 0, 0, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0);
        check("p3_flags_cv", flags, 4'b1100);
        apply(1, 0, 0, 4'hE, 4'h0, 2'b10, 0, 0, 0, 0);
        check("p3_flags_nz", flags, 4'b0000);

        // 4: stall, flush and both block everything
        apply(1, 1, 0, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        apply(1, 0, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        apply(1, 1, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        check("p4_flags", flags, 4'b0000);

        // 5: signed conditions with N=1, V=0, then N=V=1, Z=0
        apply(1, 0, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
        for (int k = 10; k <= 13; k++) apply(1, 0, 0, 4'(k), 4'h0, 2'b00, 0, 0, 1, 0);
        apply(1, 0, 0, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
        apply(1, 0, 0, 4'hC, 4'h0, 2'b00, 1, 0, 0, 0);

        // 6: reserved condition never writes
        apply(1, 0, 0, 4'hF, 4'b0110, 2'b11, 1, 1, 1, 0);
        check("p6_flags", flags, 4'b1001);

        // 7: asynchronous reset between edges
        apply(1, 0, 0, 4'hE, 4'b1011, 2'b11, 0, 0, 0, 0);
        check("p7_pre", flags, 4'b1011);
        #1 valid_in = 1'b0; rst_n = 1'b0;
        #1;
        check("p7_async_flags", flags,     4'h0);
        check("p7_async_cq",    cond_ex_q, 1'b0);
        m_flags = 4'h0; m_cq = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle();

        // Randomized traffic, including bubbles, hazards and the reserved encoding
        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(9) != 0), ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                  4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
